// File: rtl/pwm_val_loader.sv
// pwm_val_loader: double-buffered PWM limit loader.
// Commands write shadow registers in the clkCore domain. A synchronized rising
// edge of clkZ commits all shadows to the active outputs in a single cycle, so
// the downstream PWM generator never sees a half-updated A/B/en set.
module pwm_val_loader #(
  parameter int unsigned W           = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clkCore,
  input  logic           reset,
  input  logic           clkZ,
  input  logic           cmd_valid,
  input  logic [2*W+1:0] cmd_data,
  output logic           cmd_ready,
  output logic [W-1:0]   A_val,
  output logic [W-1:0]   B_val,
  output logic           en,
  output logic           pending,
  output logic           err
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StArmed  = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  localparam logic [1:0] OpLoadA    = 2'b00;
  localparam logic [1:0] OpLoadB    = 2'b01;
  localparam logic [1:0] OpLoadBoth = 2'b10;

  // Limits of 0 or 1 cannot produce a usable PWM period.
  localparam logic [W-1:0] FieldMin = W'(2);

  logic [1:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   z_prev_q;
  logic                   z_rise;
  logic                   rdy_q;
  logic [W-1:0]           shadow_a_q, shadow_b_q;
  logic [W-1:0]           a_val_q, b_val_q;
  logic                   en_req_q, en_q;
  logic                   pending_q, pending_d;
  logic                   err_q;

  logic [1:0]             opcode;
  logic [W-1:0]           fld_a, fld_b;
  logic                   accept, wr_a, wr_b, wr_en, reject, commit;

  assign opcode = cmd_data[2*W+1:2*W];
  assign fld_b  = cmd_data[2*W-1:W];
  assign fld_a  = cmd_data[W-1:0];

  assign cmd_ready = rdy_q & (state_q != StCommit);
  assign accept    = cmd_valid & cmd_ready;
  assign z_rise    = sync_q[SYNC_STAGES-1] & ~z_prev_q;
  // Copy happens on the edge entering COMMIT, so a command accepted on that
  // same edge lands in the shadows after the old values have been taken.
  assign commit    = (state_q == StArmed) & z_rise;

  // Decode an accepted command into shadow writes or a rejection.
  always_comb begin
    wr_a   = 1'b0;
    wr_b   = 1'b0;
    wr_en  = 1'b0;
    reject = 1'b0;
    if (accept) begin
      case (opcode)
        OpLoadA: begin
          if (fld_a >= FieldMin) wr_a = 1'b1;
          else                   reject = 1'b1;
        end
        OpLoadB: begin
          if (fld_b >= FieldMin) wr_b = 1'b1;
          else                   reject = 1'b1;
        end
        OpLoadBoth: begin
          if ((fld_a >= FieldMin) && (fld_b >= FieldMin)) begin
            wr_a = 1'b1;
            wr_b = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end
        default: wr_en = 1'b1;
      endcase
    end
  end

  // Pending is set by any good command, which wins over the commit clear.
  always_comb begin
    pending_d = pending_q;
    if (wr_a || wr_b || wr_en) pending_d = 1'b1;
    else if (commit)           pending_d = 1'b0;
  end

  // Commit sequencing: wait for pending, then for a clkZ edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (pending_q) state_d = StArmed;
      StArmed:  if (z_rise)    state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // clkZ synchronizer and previous-value flop for rise detection.
  always_ff @(posedge clkCore or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      z_prev_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], clkZ};
      z_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // FSM state, ready-after-reset flag, pending and sticky error.
  always_ff @(posedge clkCore or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      rdy_q     <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      pending_q <= pending_d;
      if (reject) err_q <= 1'b1;
    end
  end

  // Shadow registers written by accepted commands.
  always_ff @(posedge clkCore or negedge reset) begin
    if (!reset) begin
      shadow_a_q <= '1;
      shadow_b_q <= '1;
      en_req_q   <= 1'b0;
    end else begin
      if (wr_a)  shadow_a_q <= fld_a;
      if (wr_b)  shadow_b_q <= fld_b;
      if (wr_en) en_req_q   <= cmd_data[0];
    end
  end

  // Active outputs, updated together only on commit.
  always_ff @(posedge clkCore or negedge reset) begin
    if (!reset) begin
      a_val_q <= '1;
      b_val_q <= '1;
      en_q    <= 1'b0;
    end else if (commit) begin
      a_val_q <= shadow_a_q;
      b_val_q <= shadow_b_q;
      en_q    <= en_req_q;
    end
  end

  assign A_val   = a_val_q;
  assign B_val   = b_val_q;
  assign en      = en_q;
  assign pending = pending_q;
  assign err     = err_q;

endmodule

// File: tb/tb_pwm_val_loader.sv
// Self-checking bench for pwm_val_loader: directed scenarios plus a random
// command/commit sequence checked against a transaction-level model.
`timescale 1ns/1ps
module tb_pwm_val_loader;

  localparam int W = 7;

  logic           clkCore = 1'b0;
  logic           reset = 1'b0;
  logic           clkZ = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [2*W+1:0] cmd_data = '0;
  logic           cmd_ready;
  logic [W-1:0]   A_val, B_val;
  logic           en, pending, err;

  int checks = 0;
  int failures = 0;

  // Model: shadow and active values, updated per command / per commit.
  logic [W-1:0] m_sha, m_shb, m_a, m_b;
  logic         m_enreq, m_en, m_pend, m_err;

  int lat;
  bit saw;

  pwm_val_loader #(.W(W), .SYNC_STAGES(2)) dut (
    .clkCore   (clkCore),
    .reset     (reset),
    .clkZ      (clkZ),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .A_val     (A_val),
    .B_val     (B_val),
    .en        (en),
    .pending   (pending),
    .err       (err)
  );

  always #2.5 clkCore = ~clkCore;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sha = '1; m_shb = '1; m_a = '1; m_b = '1;
    m_enreq = 1'b0; m_en = 1'b0; m_pend = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic [W-1:0] b, input logic [W-1:0] a);
    case (op)
      2'b00: if (a < 2) m_err = 1'b1; else begin m_sha = a; m_pend = 1'b1; end
      2'b01: if (b < 2) m_err = 1'b1; else begin m_shb = b; m_pend = 1'b1; end
      2'b10: if (a < 2 || b < 2) m_err = 1'b1;
             else begin m_sha = a; m_shb = b; m_pend = 1'b1; end
      default: begin m_enreq = a[0]; m_pend = 1'b1; end
    endcase
  endtask

  task automatic model_commit();
    if (m_pend) begin
      m_a = m_sha; m_b = m_shb; m_en = m_enreq; m_pend = 1'b0;
    end
  endtask

  task automatic check_all(input string tag, input logic exp_rdy);
    chk({tag, "_A_val"}, 32'(A_val), 32'(m_a));
    chk({tag, "_B_val"}, 32'(B_val), 32'(m_b));
    chk({tag, "_en"}, 32'(en), 32'(m_en));
    chk({tag, "_pending"}, 32'(pending), 32'(m_pend));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(exp_rdy));
  endtask

  // One-beat command: waits (bounded) for ready, then one accepting edge.
  task automatic send(input logic [1:0] op, input logic [W-1:0] b, input logic [W-1:0] a);
    int n;
    @(negedge clkCore);
    cmd_valid = 1'b1;
    cmd_data  = {op, b, a};
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clkCore);
      n++;
    end
    chk("send_ready", 32'(cmd_ready), 32'd1);
    @(posedge clkCore);
    #1;
    cmd_valid = 1'b0;
    model_cmd(op, b, a);
  endtask

  // clkZ pulse with quiet time around it. lat = first cycle the outputs
  // changed (0 = never); saw = A_val took the forbidden value at some point.
  task automatic pulse_z(input logic [W-1:0] forbid, output int l, output bit s);
    logic [2*W:0] prev;
    l = 0;
    s = 1'b0;
    @(negedge clkCore);
    prev = {A_val, B_val, en};
    clkZ = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clkCore);
      #1;
      if (A_val == forbid) s = 1'b1;
      if (l == 0 && {A_val, B_val, en} != prev) l = i;
    end
    @(negedge clkCore);
    clkZ = 1'b0;
    repeat (4) @(negedge clkCore);
    model_commit();
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] fa, fb;

    // Reset state.
    model_reset();
    repeat (3) @(negedge clkCore);
    #1;
    check_all("reset", 1'b0);
    @(negedge clkCore);
    reset = 1'b1;
    @(posedge clkCore);
    #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Rejected load: err set, nothing pending, no commit on clkZ.
    send(2'b00, 7'd0, 7'd1);
    chk("rej_err", 32'(err), 32'd1);
    chk("rej_pending", 32'(pending), 32'd0);
    pulse_z(7'd0, lat, saw);
    chk("rej_no_commit", 32'(lat), 32'd0);
    check_all("rej", 1'b1);

    // Load both, enable, one clkZ edge; bounded latency.
    send(2'b10, 7'd41, 7'd40);
    chk("both_pending", 32'(pending), 32'd1);
    send(2'b11, 7'd0, 7'd1);
    pulse_z(7'd0, lat, saw);
    chk("both_latency_ok", 32'(lat >= 1 && lat <= 4), 32'd1);
    check_all("both", 1'b1);

    // Two A loads before an edge: only the last one is ever visible.
    send(2'b00, 7'd0, 7'd20);
    send(2'b00, 7'd0, 7'd30);
    pulse_z(7'd20, lat, saw);
    chk("twoload_no_20", 32'(saw), 32'd0);
    check_all("twoload", 1'b1);

    // Command accepted on the z_rise cycle, then cmd_valid held through COMMIT.
    send(2'b00, 7'd0, 7'd44);
    repeat (2) @(negedge clkCore);
    clkZ = 1'b1;
    @(posedge clkCore);
    @(posedge clkCore);
    @(negedge clkCore);
    cmd_valid = 1'b1;
    cmd_data  = {2'b00, 7'd0, 7'd55};
    @(posedge clkCore);
    #1;
    model_commit();
    model_cmd(2'b00, 7'd0, 7'd55);
    chk("race_old_commit", 32'(A_val), 32'd44);
    chk("race_pending_kept", 32'(pending), 32'd1);
    chk("hold_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clkCore);
    cmd_data = {2'b01, 7'd66, 7'd0};
    @(posedge clkCore);
    #1;
    chk("hold_ready_back", 32'(cmd_ready), 32'd1);
    chk("hold_B_unchanged", 32'(B_val), 32'd41);
    @(posedge clkCore);
    #1;
    cmd_valid = 1'b0;
    model_cmd(2'b01, 7'd66, 7'd0);
    clkZ = 1'b0;
    repeat (4) @(negedge clkCore);
    check_all("race_mid", 1'b1);
    pulse_z(7'd0, lat, saw);
    check_all("race_next", 1'b1);

    // Random commands with occasional commits.
    for (int it = 0; it < 40; it++) begin
      op = 2'($urandom_range(0, 3));
      fa = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 1)) : 7'($urandom_range(0, 127));
      fb = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 1)) : 7'($urandom_range(0, 127));
      send(op, fb, fa);
      chk("rnd_err", 32'(err), 32'(m_err));
      chk("rnd_pending", 32'(pending), 32'(m_pend));
      if ($urandom_range(0, 2) == 0) begin
        pulse_z(7'd0, lat, saw);
        check_all("rnd_commit", 1'b1);
      end
    end
    pulse_z(7'd0, lat, saw);
    check_all("rnd_final", 1'b1);

    // Reset while ARMED with A=50 pending; clkZ high across release.
    send(2'b00, 7'd0, 7'd50);
    repeat (2) @(negedge clkCore);
    reset = 1'b0;
    clkZ  = 1'b1;
    #1;
    model_reset();
    check_all("armed_reset", 1'b0);
    repeat (3) @(negedge clkCore);
    reset = 1'b1;
    @(posedge clkCore);
    #1;
    chk("armed_reset_ready", 32'(cmd_ready), 32'd1);
    repeat (6) @(negedge clkCore);
    check_all("post_reset_zhigh", 1'b1);
    clkZ = 1'b0;
    repeat (4) @(negedge clkCore);
    pulse_z(7'd0, lat, saw);
    chk("post_reset_no_commit", 32'(lat), 32'd0);
    check_all("post_reset", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
